// File: rtl/boot_loader_pkg.sv
// Shared types and helpers for the ROM-to-RAM boot image copier.
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COPY,
    VERIFY,
    DONE,
    ERROR
  } boot_state_t;

  localparam int LANES_DEF  = 2;
  localparam int MAX_BYTE_W = 16;
  localparam int MAX_BEAT_W = 128;

  // Adds the first `lanes` bytes of a beat; the caller truncates to its byte width.
  function automatic logic [MAX_BYTE_W-1:0] beat_sum(input logic [MAX_BEAT_W-1:0] beat,
                                                     input int byte_w,
                                                     input int lanes);
    logic [MAX_BEAT_W-1:0] mask;
    logic [MAX_BYTE_W-1:0] sum;
    mask = (MAX_BEAT_W'(1) << byte_w) - MAX_BEAT_W'(1);
    sum  = '0;
    for (int k = 0; k < lanes; k++) begin
      sum = sum + MAX_BYTE_W'((beat >> (k * byte_w)) & mask);
    end
    return sum;
  endfunction

endpackage

// File: rtl/boot_loader_beat_cmp.sv
// Verify-pass comparator: holds the ROM beat for one cycle so it lines up with
// the registered RAM read data.
module beat_cmp #(
  parameter int ADDR_W = 8,
  parameter int BEAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BEAT_W-1:0] rom_data,
  input  logic [BEAT_W-1:0] ram_rdata,
  output logic              mismatch,
  output logic [ADDR_W-1:0] mis_addr
);

  logic              valid_q;
  logic [BEAT_W-1:0] rom_q;
  logic [ADDR_W-1:0] addr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      rom_q   <= '0;
      addr_q  <= '0;
    end else begin
      valid_q <= issue;
      rom_q   <= rom_data;
      addr_q  <= addr;
    end
  end

  assign mismatch = valid_q && (rom_q != ram_rdata);
  assign mis_addr = addr_q;

endmodule

// File: rtl/boot_loader.sv
// ROM-to-RAM image copier with running byte checksum and optional readback verify.
// Owns the ROM/RAM address path while busy.
`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif

module boot_loader
  import boot_pkg::*;
#(
  parameter  int ADDR_W = `ADDR_SIZE,
  parameter  int BYTE_W = 8,
  parameter  int LANES  = LANES_DEF,
  localparam int BEAT_W = BYTE_W * LANES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              verify_en,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W-1:0] len,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [BEAT_W-1:0] rom_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [BEAT_W-1:0] ram_wdata,
  output logic              ram_wr_en,
  input  logic [BEAT_W-1:0] ram_rdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr,
  output logic [BYTE_W-1:0] checksum
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(LANES);

  boot_state_t       state_q;
  logic [ADDR_W-1:0] src_q, dst_q, len_q, cnt_q;
  logic [ADDR_W-1:0] rom_addr_q, ram_addr_q, err_addr_q;
  logic              verify_q, wr_en_q, rd_q, busy_q, done_q, error_q;
  logic [BYTE_W-1:0] checksum_q;
  logic              last_beat;
  logic              mismatch;
  logic [ADDR_W-1:0] mis_addr;

  assign last_beat = (cnt_q == len_q - ADDR_W'(1));

  beat_cmp #(
    .ADDR_W(ADDR_W),
    .BEAT_W(BEAT_W)
  ) u_beat_cmp (
    .clk      (clk),
    .rst      (rst),
    .issue    (rd_q),
    .addr     (ram_addr_q),
    .rom_data (rom_data),
    .ram_rdata(ram_rdata),
    .mismatch (mismatch),
    .mis_addr (mis_addr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      verify_q   <= 1'b0;
      rom_addr_q <= '0;
      ram_addr_q <= '0;
      err_addr_q <= '0;
      wr_en_q    <= 1'b0;
      rd_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      checksum_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE, ERROR: begin
          if (start) begin
            src_q      <= src_base;
            dst_q      <= dst_base;
            len_q      <= len;
            verify_q   <= verify_en;
            cnt_q      <= '0;
            checksum_q <= '0;
            err_addr_q <= '0;
            error_q    <= 1'b0;
            rom_addr_q <= src_base;
            ram_addr_q <= dst_base;
            if (len == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= COPY;
              done_q  <= 1'b0;
              wr_en_q <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
        end
        COPY: begin
          checksum_q <= checksum_q + BYTE_W'(beat_sum(MAX_BEAT_W'(rom_data), BYTE_W, LANES));
          if (last_beat) begin
            cnt_q   <= '0;
            wr_en_q <= 1'b0;
            if (verify_q) begin
              state_q    <= VERIFY;
              rom_addr_q <= src_q;
              ram_addr_q <= dst_q;
              rd_q       <= 1'b1;
            end else begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            cnt_q      <= cnt_q + ADDR_W'(1);
            rom_addr_q <= rom_addr_q + STEP;
            ram_addr_q <= ram_addr_q + STEP;
          end
        end
        VERIFY: begin
          // Compare trails issue by one cycle, so the last compare runs after rd_q drops.
          if (mismatch) begin
            state_q    <= ERROR;
            error_q    <= 1'b1;
            err_addr_q <= mis_addr;
            busy_q     <= 1'b0;
            rd_q       <= 1'b0;
          end else if (!rd_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else if (last_beat) begin
            rd_q <= 1'b0;
          end else begin
            cnt_q      <= cnt_q + ADDR_W'(1);
            rom_addr_q <= rom_addr_q + STEP;
            ram_addr_q <= ram_addr_q + STEP;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rom_addr  = rom_addr_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wr_en = wr_en_q;
  assign ram_wdata = wr_en_q ? rom_data : '0;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_addr  = err_addr_q;
  assign checksum  = checksum_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: table of copy/verify jobs plus reset and busy-start sequences.
module tb_boot_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        verify_en;
  logic [7:0]  src_base, dst_base, len;
  logic [7:0]  rom_addr, ram_addr, err_addr, checksum;
  logic [15:0] rom_data, ram_wdata, ram_rdata;
  logic        ram_wr_en, busy, done, error;

  logic [7:0]  rom_mem [256];
  logic [7:0]  ram_mem [256];
  logic        ram_clr;
  logic        force5;
  logic [7:0]  rom_a1, ram_a1;

  int checks = 0;
  int errors = 0;

  boot_loader #(
    .ADDR_W(8),
    .BYTE_W(8),
    .LANES (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .verify_en(verify_en),
    .src_base (src_base),
    .dst_base (dst_base),
    .len      (len),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_wr_en(ram_wr_en),
    .ram_rdata(ram_rdata),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .err_addr (err_addr),
    .checksum (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM byte b holds b+1; combinational two-lane read with wrap.
  assign rom_a1   = rom_addr + 8'd1;
  assign rom_data = {rom_mem[rom_a1], rom_mem[rom_addr]};
  assign ram_a1   = ram_addr + 8'd1;

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int b = 0; b < 256; b++) ram_mem[b] <= 8'h00;
    end else begin
      if (ram_wr_en) begin
        ram_mem[ram_addr] <= ram_wdata[7:0];
        ram_mem[ram_a1]   <= ram_wdata[15:8];
      end
      ram_rdata <= {(force5 && ram_a1 == 8'd5)   ? 8'hFF : ram_mem[ram_a1],
                    (force5 && ram_addr == 8'd5) ? 8'hFF : ram_mem[ram_addr]};
    end
  end

  typedef struct {
    logic [7:0] src;
    logic [7:0] dst;
    logic [7:0] ln;
    logic       verify;
    logic       frc;
    int         fin;
    logic       exp_done;
    logic       exp_err;
    logic [7:0] exp_ea;
    logic [7:0] exp_cks;
    int         exp_wr;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_ram();
    @(posedge clk); #1 ram_clr = 1'b1;
    @(posedge clk); #1 ram_clr = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int fin;
    int wr;
    fin    = -1;
    wr     = 0;
    force5 = v.frc;
    clear_ram();
    start     = 1'b1;
    src_base  = v.src;
    dst_base  = v.dst;
    len       = v.ln;
    verify_en = v.verify;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c < 100; c++) begin
      @(negedge clk);
      if (ram_wr_en) wr++;
      if (done || error) begin
        fin = c;
        break;
      end
      @(posedge clk);
    end
    $display("vec %0d src=%02h dst=%02h len=%0d ver=%0d fin=%0d done=%0d err=%0d ea=%02h cks=%02h wr=%0d",
             idx, v.src, v.dst, v.ln, v.verify, fin, done, error, err_addr, checksum, wr);
    chk($sformatf("v%0d_fin_cycle", idx), 32'(fin), 32'(v.fin));
    chk($sformatf("v%0d_done", idx), 32'(done), 32'(v.exp_done));
    chk($sformatf("v%0d_error", idx), 32'(error), 32'(v.exp_err));
    chk($sformatf("v%0d_err_addr", idx), 32'(err_addr), 32'(v.exp_ea));
    chk($sformatf("v%0d_checksum", idx), 32'(checksum), 32'(v.exp_cks));
    chk($sformatf("v%0d_wr_cycles", idx), 32'(wr), 32'(v.exp_wr));
    chk($sformatf("v%0d_busy", idx), 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; verify_en = 1'b0; ram_clr = 1'b0; force5 = 1'b0;
    src_base = '0; dst_base = '0; len = '0;
    for (int b = 0; b < 256; b++) rom_mem[b] = 8'(b + 1);

    //                 src    dst    len    ver   frc  fin done  err   ea     cks    wr
    vecs[0] = '{8'h00, 8'h00, 8'd4, 1'b0, 1'b0, 5,  1'b1, 1'b0, 8'h00, 8'h24, 4};
    vecs[1] = '{8'h00, 8'h00, 8'd4, 1'b1, 1'b0, 10, 1'b1, 1'b0, 8'h00, 8'h24, 4};
    vecs[2] = '{8'h00, 8'h00, 8'd4, 1'b1, 1'b1, 9,  1'b0, 1'b1, 8'h04, 8'h24, 4};
    vecs[3] = '{8'h00, 8'hFE, 8'd2, 1'b0, 1'b0, 3,  1'b1, 1'b0, 8'h00, 8'h0A, 2};
    vecs[4] = '{8'h00, 8'h00, 8'd0, 1'b0, 1'b0, 1,  1'b1, 1'b0, 8'h00, 8'h00, 0};
    vecs[5] = '{8'h10, 8'h40, 8'd3, 1'b1, 1'b0, 8,  1'b1, 1'b0, 8'h00, 8'h75, 3};

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_wr_en", 32'(ram_wr_en), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_wdata", 32'(ram_wdata), 32'd0);
    chk("rst_checksum", 32'(checksum), 32'd0);
    chk("rst_err_addr", 32'(err_addr), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], i);
      if (i == 0) begin
        for (int b = 0; b < 8; b++) chk($sformatf("v0_ram%0d", b), 32'(ram_mem[b]), 32'(b + 1));
      end
      if (i == 3) begin
        chk("wrap_ram_fe", 32'(ram_mem[8'hFE]), 32'd1);
        chk("wrap_ram_ff", 32'(ram_mem[8'hFF]), 32'd2);
        chk("wrap_ram_00", 32'(ram_mem[8'h00]), 32'd3);
        chk("wrap_ram_01", 32'(ram_mem[8'h01]), 32'd4);
      end
    end

    // start pulse while busy must not disturb an 8-beat copy
    begin
      int fin;
      int wr;
      fin = -1; wr = 0; force5 = 1'b0;
      clear_ram();
      start = 1'b1; src_base = 8'h00; dst_base = 8'h20; len = 8'd8; verify_en = 1'b0;
      @(posedge clk); #1;
      for (int c = 1; c < 100; c++) begin
        if (c == 3) begin
          start = 1'b1; src_base = 8'h40; dst_base = 8'h80; len = 8'd2; verify_en = 1'b1;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        if (ram_wr_en) wr++;
        if (done || error) begin
          fin = c;
          break;
        end
        @(posedge clk); #1;
      end
      start = 1'b0;
      $display("busy_start fin=%0d wr=%0d cks=%02h", fin, wr, checksum);
      chk("busy_fin_cycle", 32'(fin), 32'd9);
      chk("busy_wr_cycles", 32'(wr), 32'd8);
      chk("busy_checksum", 32'(checksum), 32'h88);
      chk("busy_ram_20", 32'(ram_mem[8'h20]), 32'd1);
      chk("busy_ram_2f", 32'(ram_mem[8'h2F]), 32'd16);
      chk("busy_ram_80", 32'(ram_mem[8'h80]), 32'd0);
    end

    // asynchronous reset in cycle 2 of an 8-beat copy
    @(posedge clk); #1;
    start = 1'b1; src_base = 8'h00; dst_base = 8'h00; len = 8'd8; verify_en = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #2;
    chk("midrst_pre_wr_en", 32'(ram_wr_en), 32'd1);
    rst = 1'b0;
    #1;
    $display("mid_reset wr_en=%0d busy=%0d done=%0d rom_addr=%02h cks=%02h",
             ram_wr_en, busy, done, rom_addr, checksum);
    chk("midrst_wr_en", 32'(ram_wr_en), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_rom_addr", 32'(rom_addr), 32'd0);
    chk("midrst_ram_addr", 32'(ram_addr), 32'd0);
    chk("midrst_checksum", 32'(checksum), 32'd0);
    @(negedge clk) rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("postrst_done", 32'(done), 32'd0);
    chk("postrst_busy", 32'(busy), 32'd0);
    chk("postrst_wr_en", 32'(ram_wr_en), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
